// File: rtl/fp_normalize_stage.sv
// fp_normalize_stage
//   Post-add normalisation stage of the 32-bit FP adder. It holds each raw
//   sum from the mantissa adder in S1 and presents it to an external leading
//   zero detector. It then normalises the mantissa, adjusts the exponent and
//   registers the result in S2 for the pack/round stage.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_ready is combinational
//   in_mant/exp/sign      raw sum (bit MANT_W = carry), biased exponent, sign
//   lzd_num/lzd_enable    S1 mantissa to the LZD, enable only when no carry
//   lzd_count             leading-zero count returned by the LZD
//   out_valid/out_ready   output handshake; out_* are held while stalled
//   out_mant/exp/sign     normalised result
//   out_guard             bit dropped by a carry right shift
//   out_zero/ovf/unf      zero, overflow-to-infinity, underflow flags
//
// Build option
//   FP_NORM_DENORM_EN     when defined, underflow produces a denormal instead
//                         of flushing to zero.

module fp_normalize_stage #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W:0]   in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic [MANT_W-1:0] lzd_num,
    output logic              lzd_enable,
    input  logic [CNT_W-1:0]  lzd_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_guard,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf
);

    localparam int XW = EXP_W + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    logic              s1_valid;
    logic [MANT_W:0]   s1_mant;
    logic [EXP_W-1:0]  s1_exp;
    logic              s1_sign;

    logic              adv1, adv2;

    logic [XW-1:0]     c_sat;
    logic [XW-1:0]     exp_x, exp_inc, exp_sub;
    logic [MANT_W-1:0] n_mant;
    logic [EXP_W-1:0]  n_exp;
    logic              n_sign, n_guard, n_zero, n_ovf, n_unf;
`ifdef FP_NORM_DENORM_EN
    logic [XW-1:0]     den_sh;
`endif

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    assign lzd_num    = s1_mant[MANT_W-1:0];
    assign lzd_enable = s1_valid & ~s1_mant[MANT_W];

    // The LZD may report more than MANT_W; anything beyond is meaningless.
    always_comb begin
        if (lzd_count > CNT_W'(MANT_W))
            c_sat = XW'(MANT_W);
        else
            c_sat = XW'(lzd_count);
    end

    // Normalisation rules, highest priority first. Exponent math is one bit
    // wider than the field so subtraction and increment never wrap.
    always_comb begin
        exp_x   = {1'b0, s1_exp};
        exp_inc = exp_x + XW'(1);
        exp_sub = exp_x - c_sat;
        n_mant  = s1_mant[MANT_W-1:0];
        n_exp   = s1_exp;
        n_sign  = s1_sign;
        n_guard = 1'b0;
        n_zero  = 1'b0;
        n_ovf   = 1'b0;
        n_unf   = 1'b0;
`ifdef FP_NORM_DENORM_EN
        den_sh  = '0;
`endif
        if (s1_exp == EXP_MAX) begin
            // Inf/NaN: pass through untouched
        end else if (s1_mant[MANT_W]) begin
            if (exp_inc == {1'b0, EXP_MAX}) begin
                n_mant = '0;
                n_exp  = EXP_MAX;
                n_ovf  = 1'b1;
            end else begin
                n_mant  = s1_mant[MANT_W:1];
                n_guard = s1_mant[0];
                n_exp   = exp_inc[EXP_W-1:0];
            end
        end else if (s1_mant == '0) begin
            n_mant = '0;
            n_exp  = '0;
            n_sign = 1'b0;
            n_zero = 1'b1;
        end else if (exp_x > c_sat) begin
            n_mant = s1_mant[MANT_W-1:0] << c_sat;
            n_exp  = exp_sub[EXP_W-1:0];
        end else begin
`ifdef FP_NORM_DENORM_EN
            den_sh = (exp_x == '0) ? '0 : exp_x - XW'(1);
            n_mant = s1_mant[MANT_W-1:0] << den_sh;
            n_exp  = '0;
            n_unf  = 1'b1;
            n_zero = (n_mant == '0);
`else
            n_mant = '0;
            n_exp  = '0;
            n_zero = 1'b1;
            n_unf  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_mant   <= '0;
            s1_exp    <= '0;
            s1_sign   <= 1'b0;
            out_valid <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_sign  <= 1'b0;
            out_guard <= 1'b0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_mant <= in_mant;
                    s1_exp  <= in_exp;
                    s1_sign <= in_sign;
                end
            end
            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_mant  <= n_mant;
                    out_exp   <= n_exp;
                    out_sign  <= n_sign;
                    out_guard <= n_guard;
                    out_zero  <= n_zero;
                    out_ovf   <= n_ovf;
                    out_unf   <= n_unf;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize_stage.sv
// tb_fp_normalize_stage
//   Self-checking bench for fp_normalize_stage. It provides an ideal leading
//   zero detector and keeps an arithmetic model of the normalisation rules. It
//   also scoreboards every output beat and checks that stalled outputs hold.
//   Define FP_NORM_DENORM_EN for both the bench and the RTL to test the
//   denormal build.

module tb_fp_normalize_stage;

    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  exp;
        logic        sign;
        logic        guard;
        logic        zero;
        logic        ovf;
        logic        unf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_mant;
    logic [7:0]  in_exp;
    logic        in_sign;
    logic [23:0] lzd_num;
    logic        lzd_enable;
    logic [7:0]  lzd_count;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_sign, out_guard, out_zero, out_ovf, out_unf;

    int checks = 0;
    int errors = 0;

    res_t q[$];
    res_t held;
    res_t cur;
    res_t ex;
    logic hold_pend = 1'b0;

    fp_normalize_stage #(.MANT_W(24), .EXP_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
        .lzd_num(lzd_num), .lzd_enable(lzd_enable), .lzd_count(lzd_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign),
        .out_guard(out_guard), .out_zero(out_zero), .out_ovf(out_ovf),
        .out_unf(out_unf)
    );

    always #5 clk = ~clk;

    // Ideal LZD: the highest set bit wins; 24 for an all-zero input
    always_comb begin
        lzd_count = 8'd24;
        for (int i = 0; i < 24; i++)
            if (lzd_num[i]) lzd_count = 8'(23 - i);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic res_t mk(logic [23:0] m, logic [7:0] e, logic s,
                                logic g, logic z, logic o, logic u);
        res_t r;
        r.mant = m; r.exp = e; r.sign = s; r.guard = g;
        r.zero = z; r.ovf = o; r.unf = u;
        return r;
    endfunction

    function automatic res_t dut_res();
        return mk(out_mant, out_exp, out_sign, out_guard, out_zero, out_ovf, out_unf);
    endfunction

    // Expected result: the value scaled by powers of two, from the rules
    function automatic res_t model(logic [24:0] m, logic [7:0] e, logic s);
        res_t r;
        int ei, mi, lz;
        r = '0;
        r.sign = s;
        ei = int'(e);
        mi = int'(m[23:0]);
        lz = 24;
        for (int i = 0; i < 24; i++)
            if (m[i]) lz = 23 - i;
        if (ei == 255) begin
            r.mant = m[23:0];
            r.exp  = e;
        end else if (m[24]) begin
            if (ei + 1 == 255) begin
                r.exp = 8'd255;
                r.ovf = 1'b1;
            end else begin
                r.mant  = 24'(int'(m) / 2);
                r.guard = m[0];
                r.exp   = 8'(ei + 1);
            end
        end else if (mi == 0) begin
            r.zero = 1'b1;
            r.sign = 1'b0;
        end else if (ei > lz) begin
            r.mant = 24'(mi * (1 << lz));
            r.exp  = 8'(ei - lz);
        end else begin
`ifdef FP_NORM_DENORM_EN
            r.mant = 24'(mi * (1 << ((ei == 0) ? 0 : ei - 1)));
            r.unf  = 1'b1;
            r.zero = (r.mant == 24'd0);
`else
            r.zero = 1'b1;
            r.unf  = 1'b1;
`endif
        end
        return r;
    endfunction

    // Scoreboard and hold monitor, sampled away from the rising edge
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold_pend = 1'b0;
        end else begin
            cur = dut_res();
            if (hold_pend) begin
                chk("hold.valid", 64'(out_valid), 64'(1'b1));
                chk("hold.data", 64'(cur), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb.extra_beat", 64'(q.size()), 64'(1));
                end else begin
                    ex = q.pop_front();
                    chk("sb.beat", 64'(cur), 64'(ex));
                end
            end
            hold_pend = out_valid && !out_ready;
            held = cur;
            if (in_valid && in_ready)
                q.push_back(model(in_mant, in_exp, in_sign));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns just after the edge that accepted it
    task automatic send(input logic [24:0] m, input logic [7:0] e, input logic s);
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        in_sign  = s;
        for (int n = 0; n < 200 && !in_ready; n++) tick();
        if (!in_ready) chk("send.timeout", 64'(in_ready), 64'(1'b1));
        tick();
        in_valid = 1'b0;
    endtask

    // One beat through an idle pipeline with literal expectations
    task automatic run1(input string nm, input logic [24:0] m, input logic [7:0] e,
                        input logic s, input res_t exp_r, input logic exp_en);
        chk({nm, ".model"}, 64'(model(m, e, s)), 64'(exp_r));
        send(m, e, s);
        chk({nm, ".lzd_enable"}, 64'(lzd_enable), 64'(exp_en));
        chk({nm, ".lzd_num"}, 64'(lzd_num), 64'(m[23:0]));
        tick();
        chk({nm, ".out_valid"}, 64'(out_valid), 64'(1'b1));
        chk({nm, ".out"}, 64'(dut_res()), 64'(exp_r));
        tick();
    endtask

    logic [24:0] vm [8];
    logic [7:0]  ve [8];
    int acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_sign = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        chk("reset.out_valid", 64'(out_valid), 64'(1'b0));
        chk("reset.out_data", 64'(dut_res()), 64'(0));
        chk("reset.lzd_enable", 64'(lzd_enable), 64'(1'b0));
        rst = 1'b0;
        chk("reset.in_ready", 64'(in_ready), 64'(1'b1));

        run1("t1_norm", 25'h0800000, 8'd127, 1'b0, mk(24'h800000, 8'd127, 0, 0, 0, 0, 0), 1'b1);
        run1("t2_carry", 25'h1800001, 8'd127, 1'b1, mk(24'hC00000, 8'd128, 1, 1, 0, 0, 0), 1'b0);
        run1("t3_shl16", 25'h0000080, 8'd127, 1'b0, mk(24'h800000, 8'd111, 0, 0, 0, 0, 0), 1'b1);
        run1("t4_zero", 25'h0000000, 8'd90, 1'b1, mk(24'h000000, 8'd0, 0, 0, 1, 0, 0), 1'b1);
`ifdef FP_NORM_DENORM_EN
        run1("t4_unf", 25'h0000001, 8'd10, 1'b1, mk(24'h000200, 8'd0, 1, 0, 0, 0, 1), 1'b1);
        run1("t4_unf_e0", 25'h0000005, 8'd0, 1'b0, mk(24'h000005, 8'd0, 0, 0, 0, 0, 1), 1'b1);
`else
        run1("t4_unf", 25'h0000001, 8'd10, 1'b1, mk(24'h000000, 8'd0, 1, 0, 1, 0, 1), 1'b1);
        run1("t4_unf_eq", 25'h0000100, 8'd15, 1'b0, mk(24'h000000, 8'd0, 0, 0, 1, 0, 1), 1'b1);
`endif
        run1("t4_eq_plus1", 25'h0000100, 8'd16, 1'b0, mk(24'h800000, 8'd1, 0, 0, 0, 0, 0), 1'b1);
        run1("t5_ovf", 25'h1000001, 8'd254, 1'b0, mk(24'h000000, 8'd255, 0, 0, 0, 1, 0), 1'b0);
        run1("t5_carry253", 25'h1000001, 8'd253, 1'b0, mk(24'h800000, 8'd254, 0, 1, 0, 0, 0), 1'b0);
        run1("t5_inf", 25'h0ABCDEF, 8'd255, 1'b1, mk(24'hABCDEF, 8'd255, 1, 0, 0, 0, 0), 1'b1);
        run1("t5_nan_carry", 25'h1000010, 8'd255, 1'b0, mk(24'h000010, 8'd255, 0, 0, 0, 0, 0), 1'b0);

        // Backpressure: only two beats fit while the output is stalled
        vm[0] = 25'h0400000; ve[0] = 8'd120;
        vm[1] = 25'h1FFFFFF; ve[1] = 8'd200;
        vm[2] = 25'h0000003; ve[2] = 8'd5;
        vm[3] = 25'h0012345; ve[3] = 8'd130;
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_mant = vm[acc]; in_exp = ve[acc]; in_sign = acc[0];
            if (in_ready) begin
                tick();
                acc++;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        chk("stall.accepted", 64'(acc), 64'(2));
        chk("stall.in_ready", 64'(in_ready), 64'(1'b0));
        chk("stall.out_valid", 64'(out_valid), 64'(1'b1));
        out_ready = 1'b1;
        for (int k = acc; k < 4; k++) send(vm[k], ve[k], k[0]);
        repeat (4) tick();
        chk("stall.drained", 64'(q.size()), 64'(0));

        // Reset with beats in flight discards them
        out_ready = 1'b0;
        send(25'h0200000, 8'd50, 1'b0);
        send(25'h0100000, 8'd60, 1'b1);
        rst = 1'b1;
        tick();
        chk("midrst.out_valid", 64'(out_valid), 64'(1'b0));
        chk("midrst.in_ready", 64'(in_ready), 64'(1'b1));
        rst = 1'b0;
        out_ready = 1'b1;
        run1("t6_after_rst", 25'h0000C00, 8'd100, 1'b0, mk(24'hC00000, 8'd88, 0, 0, 0, 0, 0), 1'b1);

        // Back-to-back stream against random output backpressure
        vm[0] = 25'h1000000; ve[0] = 8'd1;
        vm[1] = 25'h0FFFFFF; ve[1] = 8'd0;
        vm[2] = 25'h0000001; ve[2] = 8'd24;
        vm[3] = 25'h0000001; ve[3] = 8'd23;
        vm[4] = 25'h0555555; ve[4] = 8'd2;
        vm[5] = 25'h1555555; ve[5] = 8'd77;
        vm[6] = 25'h0000000; ve[6] = 8'd255;
        vm[7] = 25'h0080000; ve[7] = 8'd4;
        fork
            begin
                for (int r = 0; r < 3; r++)
                    for (int k = 0; k < 8; k++) begin
                        in_valid = 1'b1;
                        in_mant = vm[k]; in_exp = ve[k]; in_sign = k[0];
                        for (int n = 0; n < 200 && !in_ready; n++) tick();
                        tick();
                    end
                in_valid = 1'b0;
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                out_ready = 1'b1;
            end
        join

        for (int n = 0; n < 100 && q.size() != 0; n++) tick();
        tick();
        chk("final.drained", 64'(q.size()), 64'(0));
        chk("final.out_valid", 64'(out_valid), 64'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
